// File: rtl/branch_resolve_unit_if.sv
// Request/result bundle between the EX stage driver and the branch resolve unit.
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic [2:0]      in_type;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_imm;
  logic            in_pred_taken;
  logic            flush;

  logic            out_valid;
  logic            out_taken;
  logic [XLEN-1:0] out_target;
  logic            out_mispredict;
  logic [XLEN-1:0] out_redirect_pc;

  // Pipeline side: issues requests, consumes resolved results.
  modport master (
    output in_valid, in_type, in_pc, in_rs1, in_rs2, in_imm, in_pred_taken, flush,
    input  out_valid, out_taken, out_target, out_mispredict, out_redirect_pc
  );

  // Resolve unit side.
  modport slave (
    input  in_valid, in_type, in_pc, in_rs1, in_rs2, in_imm, in_pred_taken, flush,
    output out_valid, out_taken, out_target, out_mispredict, out_redirect_pc
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: evaluates compare/jump types, registers the outcome
// one cycle later, flags mispredictions and trains a bimodal 2-bit counter table.
module branch_resolve_unit #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] CNT_INIT    = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_resolve_unit_if.slave bus,
  input  logic [XLEN-1:0]      lookup_pc,
  output logic                 lookup_taken,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts
);
  localparam int IDX = $clog2(BHT_ENTRIES);

  logic            accept;
  logic            is_cond;
  logic            bht_upd;
  logic            taken;
  logic            mispredict;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fall_through;
  logic [IDX-1:0]  upd_idx;
  logic [IDX-1:0]  lookup_idx;
  logic [1:0]      bht_cnt [BHT_ENTRIES];
  logic [1:0]      upd_cur;
  logic [1:0]      upd_next;

  logic            out_valid_reg;
  logic            out_taken_reg;
  logic [XLEN-1:0] out_target_reg;
  logic            out_mispredict_reg;
  logic [XLEN-1:0] out_redirect_reg;
  logic [31:0]     stat_branches_reg;
  logic [31:0]     stat_mispredicts_reg;

  // Only the index bits of the fetch PC select a counter.
  logic unused_lookup_bits;
  assign unused_lookup_bits = ^{lookup_pc[XLEN-1:IDX+2], lookup_pc[1:0]};

  // Type 000 is reserved and silently dropped; 010..111 are conditional.
  assign is_cond      = bus.in_type[2] | bus.in_type[1];
  assign accept       = bus.in_valid & ~bus.flush & (bus.in_type != 3'b000);
  assign bht_upd      = accept & is_cond;
  assign target       = bus.in_pc + bus.in_imm;
  assign fall_through = bus.in_pc + XLEN'(4);
  assign mispredict   = taken ^ bus.in_pred_taken;
  assign upd_idx      = bus.in_pc[IDX+1:2];
  assign lookup_idx   = lookup_pc[IDX+1:2];

  // Direction decision for each branch type.
  always_comb begin
    taken = 1'b0;
    case (bus.in_type)
      3'b001:  taken = 1'b1;
      3'b010:  taken = (bus.in_rs1 == bus.in_rs2);
      3'b011:  taken = (bus.in_rs1 != bus.in_rs2);
      3'b100:  taken = ($signed(bus.in_rs1) <  $signed(bus.in_rs2));
      3'b101:  taken = ($signed(bus.in_rs1) >= $signed(bus.in_rs2));
      3'b110:  taken = (bus.in_rs1 <  bus.in_rs2);
      3'b111:  taken = (bus.in_rs1 >= bus.in_rs2);
      default: taken = 1'b0;
    endcase
  end

  // Saturating increment/decrement of the counter addressed by the branch PC.
  always_comb begin
    upd_cur  = bht_cnt[upd_idx];
    upd_next = upd_cur;
    if (taken) begin
      if (upd_cur != 2'b11) upd_next = upd_cur + 2'd1;
    end else begin
      if (upd_cur != 2'b00) upd_next = upd_cur - 2'd1;
    end
  end

  // One counter per entry; lookup reads the current (pre-update) value.
  generate
    for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
      logic [1:0] cnt_reg;
      // Counter trains only when a conditional resolves at this index.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= CNT_INIT;
        end else if (bht_upd && (upd_idx == IDX'(gi))) begin
          cnt_reg <= upd_next;
        end
      end
      assign bht_cnt[gi] = cnt_reg;
    end
  endgenerate

  assign lookup_taken = bht_cnt[lookup_idx][1];

  // Output stage: overwritten by every accept, invalidated by any idle cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg      <= 1'b0;
      out_taken_reg      <= 1'b0;
      out_target_reg     <= '0;
      out_mispredict_reg <= 1'b0;
      out_redirect_reg   <= '0;
    end else begin
      out_valid_reg <= accept;
      if (accept) begin
        out_taken_reg      <= taken;
        out_target_reg     <= target;
        out_mispredict_reg <= mispredict;
        out_redirect_reg   <= taken ? target : fall_through;
      end
    end
  end

  // Statistics counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_reg    <= '0;
      stat_mispredicts_reg <= '0;
    end else begin
      if (bht_upd)             stat_branches_reg    <= stat_branches_reg + 32'd1;
      if (accept & mispredict) stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
    end
  end

  assign bus.out_valid       = out_valid_reg;
  assign bus.out_taken       = out_taken_reg;
  assign bus.out_target      = out_target_reg;
  assign bus.out_mispredict  = out_mispredict_reg;
  assign bus.out_redirect_pc = out_redirect_reg;
  assign stat_branches       = stat_branches_reg;
  assign stat_mispredicts    = stat_mispredicts_reg;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a driver feeds requests and pushes
// expected results; a negedge monitor pops and compares registered outputs.
module tb_branch_resolve_unit;
  localparam int         XLEN = 32;
  localparam int         BHT  = 64;
  localparam logic [1:0] CINIT = 2'b01;

  typedef struct {
    logic            taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] redirect;
    logic            mis;
  } exp_t;

  logic clk;
  logic rst;
  logic [XLEN-1:0] lookup_pc;
  logic lookup_taken;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  branch_resolve_unit_if #(.XLEN(XLEN)) bus ();

  branch_resolve_unit #(.XLEN(XLEN), .BHT_ENTRIES(BHT), .CNT_INIT(CINIT)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus.slave),
    .lookup_pc        (lookup_pc),
    .lookup_taken     (lookup_taken),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  int   m_bht [BHT];
  logic [31:0] m_br;
  logic [31:0] m_mis;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic ref_taken(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (t)
      3'd1: return 1'b1;
      3'd2: return a == b;
      3'd3: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % BHT);
  endfunction

  // Monitor: every negedge, out_valid must match whether a result is owed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (bus.out_valid === 1'b1) begin
            chk("out_taken", 64'(bus.out_taken), 64'(e.taken));
            chk("out_target", 64'(bus.out_target), 64'(e.target));
            chk("out_redirect_pc", 64'(bus.out_redirect_pc), 64'(e.redirect));
            chk("out_mispredict", 64'(bus.out_mispredict), 64'(e.mis));
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    @(posedge clk);
    for (int i = 0; i < BHT; i++) m_bht[i] = int'(CINIT);
    m_br = '0;
    m_mis = '0;
    exp_q.delete();
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_taken", 64'(bus.out_taken), 64'd0);
    chk("rst_out_target", 64'(bus.out_target), 64'd0);
    chk("rst_out_redirect", 64'(bus.out_redirect_pc), 64'd0);
    chk("rst_out_mispredict", 64'(bus.out_mispredict), 64'd0);
    chk("rst_stat_branches", 64'(stat_branches), 64'd0);
    chk("rst_stat_mispredicts", 64'(stat_mispredicts), 64'd0);
    lookup_pc = 32'h0000_0040;
    #1;
    chk("rst_lookup", 64'(lookup_taken), 64'(CINIT[1]));
  endtask

  // One cycle of stimulus; called right after a rising edge.
  task automatic do_req(input bit v, input logic [2:0] t, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input bit pred, input bit fl, input logic [31:0] lpc);
    exp_t e;
    logic tk;
    int   ix;
    bus.in_valid = v;
    bus.in_type = t;
    bus.in_pc = pc;
    bus.in_rs1 = rs1;
    bus.in_rs2 = rs2;
    bus.in_imm = imm;
    bus.in_pred_taken = pred;
    bus.flush = fl;
    lookup_pc = lpc;
    #2;
    chk("lookup_taken", 64'(lookup_taken), 64'(m_bht[idx_of(lpc)] >= 2));
    @(posedge clk);
    if (v && !fl && t != 3'd0) begin
      tk = ref_taken(t, rs1, rs2);
      e.taken = tk;
      e.target = pc + imm;
      e.redirect = tk ? pc + imm : pc + 32'd4;
      e.mis = (tk != pred);
      exp_q.push_back(e);
      if (t != 3'd1) begin
        m_br = m_br + 1;
        ix = idx_of(pc);
        if (tk && m_bht[ix] < 3) m_bht[ix]++;
        else if (!tk && m_bht[ix] > 0) m_bht[ix]--;
      end
      if (e.mis) m_mis = m_mis + 1;
    end
    #1;
    chk("stat_branches", 64'(stat_branches), 64'(m_br));
    chk("stat_mispredicts", 64'(stat_mispredicts), 64'(m_mis));
  endtask

  task automatic idle(input logic [31:0] lpc);
    do_req(1'b0, 3'd2, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, lpc);
  endtask

  initial begin
    logic [2:0]  t;
    logic [31:0] pc, rs1, rs2, lpc;
    clk = 1'b0;
    rst = 1'b1;
    lookup_pc = '0;
    bus.in_valid = 1'b0;
    bus.in_type = 3'd0;
    bus.in_pc = '0;
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    bus.in_imm = '0;
    bus.in_pred_taken = 1'b0;
    bus.flush = 1'b0;
    do_reset();

    // Compare sweep with rs1=-1, rs2=1.
    for (int k = 2; k < 8; k++)
      do_req(1'b1, 3'(k), 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h10, 1'b0, 1'b0, 32'h200);

    // Target wrap, taken and not taken.
    do_req(1'b1, 3'd2, 32'hFFFF_FFFC, 32'h5, 32'h5, 32'h8, 1'b1, 1'b0, 32'h0);
    do_req(1'b1, 3'd2, 32'hFFFF_FFFC, 32'h5, 32'h6, 32'h8, 1'b1, 1'b0, 32'h0);

    // Counter saturation then decay at 0x100.
    for (int k = 0; k < 5; k++)
      do_req(1'b1, 3'd2, 32'h100, 32'h7, 32'h7, 32'h20, 1'b1, 1'b0, 32'h100);
    for (int k = 0; k < 4; k++)
      do_req(1'b1, 3'd2, 32'h100, 32'h7, 32'h8, 32'h20, 1'b0, 1'b0, 32'h100);
    idle(32'h100);

    // Mispredicted BNE, then JAL that must not train the table.
    do_req(1'b1, 3'd3, 32'h300, 32'h1, 32'h2, 32'h40, 1'b0, 1'b0, 32'h300);
    do_req(1'b1, 3'd1, 32'h300, 32'h0, 32'h0, 32'h80, 1'b1, 1'b0, 32'h300);
    idle(32'h300);

    // Same-index collision from a fresh table.
    do_reset();
    do_req(1'b1, 3'd2, 32'h40, 32'h3, 32'h3, 32'h4, 1'b0, 1'b0, 32'h40);
    idle(32'h40);

    // Flush while a result is still registered, and reserved type.
    do_req(1'b1, 3'd2, 32'h40, 32'h3, 32'h3, 32'h4, 1'b1, 1'b0, 32'h40);
    do_req(1'b1, 3'd2, 32'h40, 32'h3, 32'h3, 32'h4, 1'b1, 1'b1, 32'h40);
    do_req(1'b1, 3'd0, 32'h40, 32'h3, 32'h3, 32'h4, 1'b1, 1'b0, 32'h40);
    idle(32'h40);

    // Reset the cycle after a request.
    do_req(1'b1, 3'd3, 32'h80, 32'h1, 32'h2, 32'h4, 1'b0, 1'b0, 32'h80);
    do_reset();

    // Randomized traffic over a small PC range to force index reuse.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        t = 3'($urandom_range(0, 7));
        pc = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 95)) * 4;
        rs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
        rs2 = ($urandom_range(0, 2) == 0) ? rs1 : $urandom();
        lpc = ($urandom_range(0, 1) == 0) ? pc : 32'($urandom_range(0, 95)) * 4;
        do_req(($urandom_range(0, 7) != 0), t, pc, rs1, rs2, $urandom(),
               1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), lpc);
      end
    end
    idle(32'h0);
    idle(32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
